mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Moore state-machine controller for the multicycle MIPS datapath. Decodes the instruction register's opcode and funct fields and drives every datapath select and write-enable, one state per cycle, so that fetch, decode, execute, memory and write-back share a single ALU and a single memory port. Sits beside `Datapath`; together with a unified instruction/data memory they form the complete processor.

## Interface
Parameters: none; encodings are fixed by the datapath.

- `ck` in 1: clock; all state updates on rising edge
- `reset` in 1: synchronous, active-high; forces state FETCH and clears `ovf_q`
- `Op` in 6: instruction[31:26] from datapath IR
- `Funct` in 6: instruction[5:0] from datapath IR
- `overflow` in 1: ALU signed overflow from datapath
- `IorD` out 1: memory address select, 0 = PC, 1 = ALUOut
- `IRWrite` out 1: load instruction register
- `RegDest` out 1: write register select, 0 = rt, 1 = rd
- `MemtoReg` out 1: write data select, 0 = ALUOut, 1 = memory data
- `RegWrite` out 1: register file write enable
- `MemWrite` out 1: memory write enable
- `ALUSrcA` out 1: 0 = PC, 1 = register A
- `ALUSrcB` out 2: 00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- `ALUControl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt
- `PCSrc` out 2: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- `Branch` out 1: PC load qualified by Zero inside datapath
- `PCWrite` out 1: unconditional PC load
- `illegal` out 1: single-cycle pulse on unsupported opcode or funct
- `ovf_trap` out 1: single-cycle pulse when a signed write-back is suppressed
- `state` out 4: current state encoding, for debug

## Operation
- Pure Moore outputs, decoded combinationally from the registered state and from `Op`/`Funct`/`ovf_q`. Every output not listed for a state is 0.
- Opcodes: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- R-type funct decoding:
  - add 100000 → 010, signed
  - sub 100010 → 110, signed
  - and 100100 → 000
  - or 100101 → 001
  - slt 101010 → 111
  - any other funct → 010 and flagged bad
- States, in the encoding exposed on `state`:
  - FETCH(0): IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00, IRWrite=1, PCWrite=1. Next: DECODE.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next by opcode:
    - lw/sw → MEMADR
    - R-type → EXECUTE
    - beq → BRANCH
    - addi → ADDIEX
    - j → JUMP
    - other → FETCH, with `illegal`=1
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next: MEMRD if lw, MEMWR if sw.
  - MEMRD(3): IorD=1. Next: MEMWB.
  - MEMWB(4): RegDest=0, MemtoReg=1, RegWrite=1. Next: FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. Next: FETCH.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUControl from funct. Next: ALUWB.
  - ALUWB(7): RegDest=1, MemtoReg=0, RegWrite=!(ovf_q | bad funct). `illegal`=1 if bad funct. `ovf_trap`=ovf_q. Next: FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUControl=110, PCSrc=01, Branch=1. Next: FETCH.
  - ADDIEX(9): ALUSrcA=1, ALUSrcB=10, ALUControl=010. Next: ADDIWB.
  - ADDIWB(10): RegDest=0, MemtoReg=0, RegWrite=!ovf_q, `ovf_trap`=ovf_q. Next: FETCH.
  - JUMP(11): PCSrc=10, PCWrite=1. Next: FETCH.
  - Codes 12–15 are unreachable and go to FETCH.
- `ovf_q` (internal register):
  - Loaded with `overflow` at the end of EXECUTE when funct is add or sub.
  - Loaded with `overflow` at the end of ADDIEX.
  - Cleared in every other state and on reset.
  - and/or/slt never trap.
- A suppressed write leaves the PC already advanced; execution resumes at the next instruction.

## Timing
- Reset is sampled on the rising edge of `ck`. The cycle after reset is released is FETCH, so outputs out of reset equal the FETCH outputs listed above.
- Reset asserted mid-instruction: the next state is FETCH regardless of the current state. RegWrite, MemWrite and PCWrite take effect only in the state they belong to, so no partial write-back occurs after reset is applied.
- Cycles per instruction, FETCH inclusive:

| Instruction | Cycles |
|---|---|
| lw | 5 |
| sw | 4 |
| R-type | 4 |
| addi | 4 |
| beq | 3 |
| j | 3 |
| illegal opcode | 2 |

- `Op`/`Funct` are sampled only in DECODE, MEMADR, EXECUTE and ALUWB. The IR is stable from the edge ending FETCH, so no further input registering is needed.
- `illegal` and `ovf_trap` are high for exactly one cycle per event.

## Test plan
- Reset held for 2 cycles, then released → `state`=0; IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=010; next cycle `state`=1.
- lw (Op=100011) → `state` sequence 0,1,2,3,4,0. MEMRD has IorD=1. MEMWB has MemtoReg=1, RegWrite=1, RegDest=0.
- sw, then beq → sw: 0,1,2,5,0 with MemWrite=1 only in state 5. beq: 0,1,8,0 with Branch=1, PCSrc=01, ALUControl=110 in state 8.
- R-type, one instruction for each of add, sub, and, or, slt → EXECUTE ALUControl = 010, 110, 000, 001, 111 respectively; ALUWB has RegWrite=1, RegDest=1. Funct 000111 → ALUWB has RegWrite=0, `illegal`=1 for one cycle.
- addi with `overflow`=1 during ADDIEX → ADDIWB has RegWrite=0, `ovf_trap`=1; the next addi with `overflow`=0 → RegWrite=1. and with `overflow`=1 → no trap.
- j → 0,1,11,0 with PCSrc=10, PCWrite=1. Op=111111 → 0,1,0 with `illegal`=1 in DECODE. Reset asserted during MEMRD → next `state`=0 and MemtoReg/RegWrite never asserted.

Source files
------------

// File: rtl/mips_multicycle_control_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control_if
// Purpose  : Instruction-field inputs and control outputs exchanged between
//            the multicycle controller and the MIPS datapath.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_multicycle_control_if;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       overflow;
    logic       IorD;
    logic       IRWrite;
    logic       RegDest;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] PCSrc;
    logic       Branch;
    logic       PCWrite;
    logic       illegal;
    logic       ovf_trap;
    logic [3:0] state;

    modport master (
        input  Op, Funct, overflow,
        output IorD, IRWrite, RegDest, MemtoReg, RegWrite, MemWrite, ALUSrcA,
               ALUSrcB, ALUControl, PCSrc, Branch, PCWrite, illegal, ovf_trap,
               state
    );

    modport slave (
        output Op, Funct, overflow,
        input  IorD, IRWrite, RegDest, MemtoReg, RegWrite, MemWrite, ALUSrcA,
               ALUSrcB, ALUControl, PCSrc, Branch, PCWrite, illegal, ovf_trap,
               state
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_control
// Purpose  : Moore FSM sequencing fetch/decode/execute/memory/write-back for
//            the multicycle MIPS datapath, with overflow-suppressed write-back.
// Revision : 1.0 - initial release
// ============================================================================
module mips_multicycle_control (
    input  wire logic                       ck,
    input  wire logic                       reset,
    mips_multicycle_control_if.master       bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] C_OP_LW   = 6'b100011;
    localparam logic [5:0] C_OP_SW   = 6'b101011;
    localparam logic [5:0] C_OP_R    = 6'b000000;
    localparam logic [5:0] C_OP_BEQ  = 6'b000100;
    localparam logic [5:0] C_OP_ADDI = 6'b001000;
    localparam logic [5:0] C_OP_J    = 6'b000010;

    state_t     r_state;
    state_t     w_next_state;
    logic       r_ovf_q;
    logic       w_ovf_d;
    logic [2:0] w_funct_ctl;
    logic       w_bad_funct;
    logic       w_signed_funct;

    always_ff @(posedge ck) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ovf_q <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ovf_q <= w_ovf_d;
        end
    end

    always_comb begin
        w_funct_ctl    = 3'b010;
        w_bad_funct    = 1'b0;
        w_signed_funct = 1'b0;
        case (bus.Funct)
            6'b100000: w_signed_funct = 1'b1;
            6'b100010: begin
                w_funct_ctl    = 3'b110;
                w_signed_funct = 1'b1;
            end
            6'b100100: w_funct_ctl = 3'b000;
            6'b100101: w_funct_ctl = 3'b001;
            6'b101010: w_funct_ctl = 3'b111;
            default:   w_bad_funct = 1'b1;
        endcase
    end

    assign bus.state = r_state;

    always_comb begin
        w_next_state   = S_FETCH;
        w_ovf_d        = 1'b0;
        bus.IorD       = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegDest    = 1'b0;
        bus.MemtoReg   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ALUControl = 3'b000;
        bus.PCSrc      = 2'b00;
        bus.Branch     = 1'b0;
        bus.PCWrite    = 1'b0;
        bus.illegal    = 1'b0;
        bus.ovf_trap   = 1'b0;
        case (r_state)
            S_FETCH: begin
                bus.ALUSrcB    = 2'b01;
                bus.ALUControl = 3'b010;
                bus.IRWrite    = 1'b1;
                bus.PCWrite    = 1'b1;
                w_next_state   = S_DECODE;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut
                bus.ALUSrcB    = 2'b11;
                bus.ALUControl = 3'b010;
                case (bus.Op)
                    C_OP_LW, C_OP_SW: w_next_state = S_MEMADR;
                    C_OP_R:           w_next_state = S_EXECUTE;
                    C_OP_BEQ:         w_next_state = S_BRANCH;
                    C_OP_ADDI:        w_next_state = S_ADDIEX;
                    C_OP_J:           w_next_state = S_JUMP;
                    default:          bus.illegal  = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = 3'b010;
                if (bus.Op == C_OP_LW)
                    w_next_state = S_MEMRD;
                else if (bus.Op == C_OP_SW)
                    w_next_state = S_MEMWR;
            end
            S_MEMRD: begin
                bus.IorD     = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                bus.MemtoReg = 1'b1;
                bus.RegWrite = 1'b1;
            end
            S_MEMWR: begin
                bus.IorD     = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = w_funct_ctl;
                w_ovf_d        = w_signed_funct & bus.overflow;
                w_next_state   = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegDest  = 1'b1;
                bus.RegWrite = ~(r_ovf_q | w_bad_funct);
                bus.illegal  = w_bad_funct;
                bus.ovf_trap = r_ovf_q;
            end
            S_BRANCH: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUControl = 3'b110;
                bus.PCSrc      = 2'b01;
                bus.Branch     = 1'b1;
            end
            S_ADDIEX: begin
                bus.ALUSrcA    = 1'b1;
                bus.ALUSrcB    = 2'b10;
                bus.ALUControl = 3'b010;
                w_ovf_d        = bus.overflow;
                w_next_state   = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.RegWrite = ~r_ovf_q;
                bus.ovf_trap = r_ovf_q;
            end
            S_JUMP: begin
                bus.PCSrc   = 2'b10;
                bus.PCWrite = 1'b1;
            end
            default: w_next_state = S_FETCH;
        endcase
    end
endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_multicycle_control
// Purpose  : Directed per-cycle vector bench for mips_multicycle_control.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_control;
    logic ck = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    mips_multicycle_control_if bus ();
    mips_multicycle_control dut (.ck(ck), .reset(reset), .bus(bus));

    always #5 ck = ~ck;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
    localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_BAD = 6'b000111;

    // Field order: IorD IRWrite RegDest MemtoReg RegWrite MemWrite ALUSrcA
    // ALUSrcB[2] ALUControl[3] PCSrc[2] Branch PCWrite illegal ovf_trap
    function automatic logic [17:0] mk(logic iord, logic irw, logic rd, logic m2r,
                                       logic rw, logic mw, logic sa, logic [1:0] sb,
                                       logic [2:0] ac, logic [1:0] pcs, logic br,
                                       logic pcw, logic ill, logic ot);
        return {iord, irw, rd, m2r, rw, mw, sa, sb, ac, pcs, br, pcw, ill, ot};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        ovf;
        logic        chk;
        logic [3:0]  st;
        logic [17:0] out;
    } vec_t;

    vec_t vq[$];

    task automatic add(logic rst, logic [5:0] op, logic [5:0] fn, logic ovf,
                       logic [3:0] st, logic [17:0] out);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.ovf = ovf; v.chk = 1'b1;
        v.st = st; v.out = out;
        vq.push_back(v);
    endtask

    function automatic logic [17:0] actual_out();
        return {bus.IorD, bus.IRWrite, bus.RegDest, bus.MemtoReg, bus.RegWrite,
                bus.MemWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.PCSrc,
                bus.Branch, bus.PCWrite, bus.illegal, bus.ovf_trap};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts cycles from FETCH (inclusive) until the FSM returns to FETCH
    task automatic cpi(string name, logic [5:0] op, logic [5:0] fn, int exp_cycles);
        int cycles;
        @(negedge ck);
        reset = 1'b1; bus.Op = op; bus.Funct = fn; bus.overflow = 1'b0;
        @(negedge ck);
        reset = 1'b0;
        cycles = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge ck);
            #1;
            if (bus.state == 4'd0) break;
            cycles++;
        end
        check(name, cycles, exp_cycles);
    endtask

    logic [17:0] O_FETCH, O_DEC, O_DEC_ILL, O_MADR, O_MRD, O_MWB, O_MWR;
    logic [17:0] O_WB, O_WB_BAD, O_WB_OVF, O_BR, O_AEX, O_AWB, O_AWB_OVF, O_J;

    function automatic logic [17:0] o_exec(logic [2:0] ac);
        return mk(0,0,0,0,0,0,1,2'b00,ac,2'b00,0,0,0,0);
    endfunction

    initial begin
        O_FETCH   = mk(0,1,0,0,0,0,0,2'b01,3'b010,2'b00,0,1,0,0);
        O_DEC     = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,0,0);
        O_DEC_ILL = mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0,1,0);
        O_MADR    = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0,0);
        O_MRD     = mk(1,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,0);
        O_MWB     = mk(0,0,0,1,1,0,0,2'b00,3'b000,2'b00,0,0,0,0);
        O_MWR     = mk(1,0,0,0,0,1,0,2'b00,3'b000,2'b00,0,0,0,0);
        O_WB      = mk(0,0,1,0,1,0,0,2'b00,3'b000,2'b00,0,0,0,0);
        O_WB_BAD  = mk(0,0,1,0,0,0,0,2'b00,3'b000,2'b00,0,0,1,0);
        O_WB_OVF  = mk(0,0,1,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,1);
        O_BR      = mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,1,0,0,0);
        O_AEX     = mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0,0);
        O_AWB     = mk(0,0,0,0,1,0,0,2'b00,3'b000,2'b00,0,0,0,0);
        O_AWB_OVF = mk(0,0,0,0,0,0,0,2'b00,3'b000,2'b00,0,0,0,1);
        O_J       = mk(0,0,0,0,0,0,0,2'b00,3'b000,2'b10,0,1,0,0);

        // Reset for two cycles; the first cycle's state is not yet defined
        add(1, LW, 0, 0, 0, O_FETCH); vq[0].chk = 1'b0;
        add(1, LW, 0, 0, 0, O_FETCH);
        // lw
        add(0, LW, 0, 0, 0, O_FETCH); add(0, LW, 0, 0, 1, O_DEC);
        add(0, LW, 0, 0, 2, O_MADR);  add(0, LW, 0, 0, 3, O_MRD);
        add(0, LW, 0, 0, 4, O_MWB);
        // sw, beq
        add(0, SW, 0, 0, 0, O_FETCH); add(0, SW, 0, 0, 1, O_DEC);
        add(0, SW, 0, 0, 2, O_MADR);  add(0, SW, 0, 0, 5, O_MWR);
        add(0, BEQ, 0, 0, 0, O_FETCH); add(0, BEQ, 0, 0, 1, O_DEC);
        add(0, BEQ, 0, 0, 8, O_BR);
        // R-type: add sub and or slt, then bad funct
        add(0, RT, F_ADD, 0, 0, O_FETCH); add(0, RT, F_ADD, 0, 1, O_DEC);
        add(0, RT, F_ADD, 0, 6, o_exec(3'b010)); add(0, RT, F_ADD, 0, 7, O_WB);
        add(0, RT, F_SUB, 0, 0, O_FETCH); add(0, RT, F_SUB, 0, 1, O_DEC);
        add(0, RT, F_SUB, 0, 6, o_exec(3'b110)); add(0, RT, F_SUB, 0, 7, O_WB);
        add(0, RT, F_AND, 0, 0, O_FETCH); add(0, RT, F_AND, 0, 1, O_DEC);
        add(0, RT, F_AND, 0, 6, o_exec(3'b000)); add(0, RT, F_AND, 0, 7, O_WB);
        add(0, RT, F_OR, 0, 0, O_FETCH); add(0, RT, F_OR, 0, 1, O_DEC);
        add(0, RT, F_OR, 0, 6, o_exec(3'b001)); add(0, RT, F_OR, 0, 7, O_WB);
        add(0, RT, F_SLT, 0, 0, O_FETCH); add(0, RT, F_SLT, 0, 1, O_DEC);
        add(0, RT, F_SLT, 0, 6, o_exec(3'b111)); add(0, RT, F_SLT, 0, 7, O_WB);
        add(0, RT, F_BAD, 0, 0, O_FETCH); add(0, RT, F_BAD, 0, 1, O_DEC);
        add(0, RT, F_BAD, 0, 6, o_exec(3'b010)); add(0, RT, F_BAD, 0, 7, O_WB_BAD);
        // addi overflowing, then clean addi
        add(0, ADDI, 0, 0, 0, O_FETCH); add(0, ADDI, 0, 0, 1, O_DEC);
        add(0, ADDI, 0, 1, 9, O_AEX);   add(0, ADDI, 0, 0, 10, O_AWB_OVF);
        add(0, ADDI, 0, 0, 0, O_FETCH); add(0, ADDI, 0, 0, 1, O_DEC);
        add(0, ADDI, 0, 0, 9, O_AEX);   add(0, ADDI, 0, 0, 10, O_AWB);
        // and with overflow never traps; add with overflow does
        add(0, RT, F_AND, 0, 0, O_FETCH); add(0, RT, F_AND, 0, 1, O_DEC);
        add(0, RT, F_AND, 1, 6, o_exec(3'b000)); add(0, RT, F_AND, 0, 7, O_WB);
        add(0, RT, F_ADD, 0, 0, O_FETCH); add(0, RT, F_ADD, 0, 1, O_DEC);
        add(0, RT, F_ADD, 1, 6, o_exec(3'b010)); add(0, RT, F_ADD, 0, 7, O_WB_OVF);
        // j, illegal opcode
        add(0, JMP, 0, 0, 0, O_FETCH); add(0, JMP, 0, 0, 1, O_DEC);
        add(0, JMP, 0, 0, 11, O_J);
        add(0, 6'b111111, 0, 0, 0, O_FETCH); add(0, 6'b111111, 0, 0, 1, O_DEC_ILL);
        // lw interrupted by reset in MEMRD: no MEMWB follows
        add(0, LW, 0, 0, 0, O_FETCH); add(0, LW, 0, 0, 1, O_DEC);
        add(0, LW, 0, 0, 2, O_MADR);  add(1, LW, 0, 0, 3, O_MRD);
        add(0, LW, 0, 0, 0, O_FETCH); add(0, LW, 0, 0, 1, O_DEC);

        bus.Op = 6'd0; bus.Funct = 6'd0; bus.overflow = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge ck);
            reset = vq[i].rst; bus.Op = vq[i].op; bus.Funct = vq[i].fn;
            bus.overflow = vq[i].ovf;
            #1;
            if (vq[i].chk) begin
                check($sformatf("vec%0d state", i), 32'(bus.state), 32'(vq[i].st));
                check($sformatf("vec%0d outputs", i), 32'(actual_out()), 32'(vq[i].out));
            end
        end

        cpi("cpi lw", LW, 0, 5);
        cpi("cpi sw", SW, 0, 4);
        cpi("cpi rtype", RT, F_OR, 4);
        cpi("cpi addi", ADDI, 0, 4);
        cpi("cpi beq", BEQ, 0, 3);
        cpi("cpi j", JMP, 0, 3);
        cpi("cpi illegal", 6'b110000, 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
